// File: rtl/mips_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline.
// A small destination scoreboard tracks register writes in flight in the
// execute, memory and write-back stages. Decode reads that hit the scoreboard
// stall fetch and inject a bubble. Taken branches and jumps flush the wrong-path
// instruction in decode.
//
// Qualification rule: decode inputs (d_rs, d_rt, d_use_*, d_wr*, d_jump) are
// only meaningful while d_valid=1. Nothing is issued, stalled or redirected
// because of them when d_valid=0. There is no back-pressure input: an
// instruction issues in the same cycle it is presented without a hazard.
module mips_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic        d_wr,
  input  logic [4:0]  d_wr_addr,
  input  logic        d_jump,
  input  logic        br_taken,
  input  logic        clr_cnt,
  output logic        stall_f,
  output logic        bubble_e,
  output logic        flush_d,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;

  // Entry 0 = execute, 1 = memory, 2 = write-back.
  logic [2:0] sb_valid;
  logic [4:0] sb_addr [3];

  logic       rs_hit;
  logic       rt_hit;
  logic       raw;
  logic       issue;

  // Compare both decode sources against every live scoreboard entry.
  // The write-back entry is included because the register bank only updates
  // at the end of that cycle.
  always_comb begin
    rs_hit = (sb_valid[0] && (sb_addr[0] == d_rs)) ||
             (sb_valid[1] && (sb_addr[1] == d_rs)) ||
             (sb_valid[2] && (sb_addr[2] == d_rs));
    rt_hit = (sb_valid[0] && (sb_addr[0] == d_rt)) ||
             (sb_valid[1] && (sb_addr[1] == d_rt)) ||
             (sb_valid[2] && (sb_addr[2] == d_rt));
    raw    = d_valid &&
             ((d_use_rs && (d_rs != 5'd0) && rs_hit) ||
              (d_use_rt && (d_rt != 5'd0) && rt_hit));
  end

  // Control outputs and next state, priority: branch > pending flush > raw > jump.
  // A jump that also has a raw hazard (jr on a pending rs) stalls first.
  always_comb begin
    stall_f  = 1'b0;
    bubble_e = 1'b0;
    flush_d  = 1'b0;
    state_d  = ST_RUN;
    if (rst) begin
      state_d = ST_RUN;
    end else if (br_taken) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
      state_d  = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
      state_d  = ST_RUN;
    end else if (raw) begin
      stall_f  = 1'b1;
      bubble_e = 1'b1;
      state_d  = ST_STALL;
    end else if (d_valid && d_jump) begin
      state_d = ST_FLUSH;
    end
  end

  assign issue = d_valid && !raw && !flush_d;
  assign state = state_q;

  // Scoreboard shift, FSM state and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid  <= 3'b000;
      sb_addr[0] <= 5'd0;
      sb_addr[1] <= 5'd0;
      sb_addr[2] <= 5'd0;
      state_q   <= ST_RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      sb_valid[2] <= sb_valid[1];
      sb_addr[2]  <= sb_addr[1];
      sb_valid[1] <= sb_valid[0];
      sb_addr[1]  <= sb_addr[0];
      // Writes to r0 are never tracked so r0 can never raise a hazard.
      sb_valid[0] <= issue && d_wr && (d_wr_addr != 5'd0);
      sb_addr[0]  <= issue ? d_wr_addr : 5'd0;
      state_q     <= state_d;
      if (clr_cnt) begin
        stall_cnt <= 16'd0;
        flush_cnt <= 16'd0;
      end else begin
        if (stall_f && (stall_cnt != 16'hFFFF)) begin
          stall_cnt <= stall_cnt + 16'd1;
        end
        if (flush_d && (flush_cnt != 16'hFFFF)) begin
          flush_cnt <= flush_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl.
// Each cycle is described as a stimulus record carrying the expected
// {state, stall_f, bubble_e, flush_d} vector. The expected vector is queued
// when the stimulus is driven and popped when the outputs are sampled.
module tb_mips_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_use_rs;
  logic        d_use_rt;
  logic        d_wr;
  logic [4:0]  d_wr_addr;
  logic        d_jump;
  logic        br_taken;
  logic        clr_cnt;
  logic        stall_f;
  logic        bubble_e;
  logic        flush_d;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] wa;
    logic       j;
    logic       br;
    logic [4:0] exp;
  } stim_t;

  logic [4:0]  exp_q[$];
  logic [4:0]  obs_v;
  logic [4:0]  exp_v;
  logic [15:0] exp_stall_cnt;
  logic [15:0] exp_flush_cnt;
  int          n_cmp;
  int          n_bad;

  mips_hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_use_rs  (d_use_rs),
    .d_use_rt  (d_use_rt),
    .d_wr      (d_wr),
    .d_wr_addr (d_wr_addr),
    .d_jump    (d_jump),
    .br_taken  (br_taken),
    .clr_cnt   (clr_cnt),
    .stall_f   (stall_f),
    .bubble_e  (bubble_e),
    .flush_d   (flush_d),
    .state     (state),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Build one stimulus record; exp = {state, stall_f, bubble_e, flush_d}.
  function automatic stim_t st(input logic r, input logic c, input logic v,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic wr, input logic [4:0] wa,
                               input logic j, input logic br,
                               input logic [4:0] exp);
    stim_t s;
    s.rst = r;  s.clr = c;  s.v = v;   s.rs = rs;  s.rt = rt;
    s.urs = urs; s.urt = urt; s.wr = wr; s.wa = wa; s.j = j; s.br = br;
    s.exp = exp;
    return s;
  endfunction

  function automatic stim_t idle(input logic [4:0] exp);
    return st(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
  endfunction

  // Driver: apply one cycle of stimulus on the falling edge, queue its
  // expectation, sample outputs 1 time unit later, and advance the
  // expected counters to what they should hold after the next rising edge.
  task automatic drive_cycle(input stim_t s);
    @(negedge clk);
    rst       = s.rst;
    clr_cnt   = s.clr;
    d_valid   = s.v;
    d_rs      = s.rs;
    d_rt      = s.rt;
    d_use_rs  = s.urs;
    d_use_rt  = s.urt;
    d_wr      = s.wr;
    d_wr_addr = s.wa;
    d_jump    = s.j;
    br_taken  = s.br;
    exp_q.push_back(s.exp);
    #1;
    obs_v = {state, stall_f, bubble_e, flush_d};
    if (s.rst || s.clr) begin
      exp_stall_cnt = 16'd0;
      exp_flush_cnt = 16'd0;
    end else begin
      if (s.exp[2] && exp_stall_cnt != 16'hFFFF) exp_stall_cnt = exp_stall_cnt + 16'd1;
      if (s.exp[0] && exp_flush_cnt != 16'hFFFF) exp_flush_cnt = exp_flush_cnt + 16'd1;
    end
  endtask

  task automatic test_reset();
    stim_t t[$];
    t.push_back(st(1, 0, 1, 5'd3, 5'd4, 1, 1, 1, 5'd3, 1, 1, 5'b00000));
    t.push_back(st(1, 1, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'b00000));
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_r0_and_unused();
    stim_t t[$];
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 5'b00000)); // write r0
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0, 5'b00000)); // read r0
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd4, 0, 0, 5'b00000)); // write r4
    t.push_back(st(0, 0, 1, 5'd4, 5'd5, 0, 1, 0, 5'd0, 0, 0, 5'b00000)); // rs=4 unused
    t.push_back(idle(5'b00000));
    t.push_back(idle(5'b00000));
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL r0[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (stall_cnt !== exp_stall_cnt) begin
      n_bad++;
      $display("FAIL r0_stall_cnt: got %h want %h", stall_cnt, exp_stall_cnt);
    end
  endtask

  task automatic test_raw();
    stim_t t[$];
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0, 5'b00000));  // add r3
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b00110));  // reader rs=3
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b01110));
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b01110));
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b01000));  // issues
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd12, 0, 0, 5'b00000)); // write r12
    t.push_back(st(0, 0, 1, 5'd1, 5'd12, 0, 1, 0, 5'd0, 0, 0, 5'b00110)); // reader rt=12
    t.push_back(st(0, 0, 1, 5'd1, 5'd12, 0, 1, 0, 5'd0, 0, 0, 5'b01110));
    t.push_back(idle(5'b01000));                                           // bubble leaves decode
    t.push_back(idle(5'b00000));
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL raw[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (stall_cnt !== exp_stall_cnt) begin
      n_bad++;
      $display("FAIL raw_stall_cnt: got %h want %h", stall_cnt, exp_stall_cnt);
    end
  endtask

  task automatic test_jump();
    stim_t t[$];
    t.push_back(st(0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'b00000));  // clear counters
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 5'b00000));  // j
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd6, 0, 0, 5'b10011));  // killed write r6
    t.push_back(st(0, 0, 1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b00000));  // r6 never tracked
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 0, 0, 5'b00000));  // write r9
    t.push_back(st(0, 0, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 0, 5'b00110));  // jr r9 stalls
    t.push_back(st(0, 0, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 0, 5'b01110));
    t.push_back(st(0, 0, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 0, 5'b01110));
    t.push_back(st(0, 0, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 1, 0, 5'b01000));  // jr issues
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'b10011));  // delay slot killed
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL jump[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {exp_stall_cnt, exp_flush_cnt}) begin
      n_bad++;
      $display("FAIL jump_cnt: got %h/%h want %h/%h", stall_cnt, flush_cnt,
               exp_stall_cnt, exp_flush_cnt);
    end
  endtask

  task automatic test_branch();
    stim_t t[$];
    t.push_back(st(0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'b00000));  // clear counters
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, 5'b00000));  // write r7
    t.push_back(st(0, 0, 1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 1, 1, 5'b00011));  // jr r7 + branch
    t.push_back(st(0, 0, 1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 1, 0, 5'b10011));  // FLUSH
    t.push_back(idle(5'b00000));
    t.push_back(idle(5'b00000));
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL branch[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (flush_cnt !== exp_flush_cnt) begin
      n_bad++;
      $display("FAIL branch_flush_cnt: got %h want %h", flush_cnt, exp_flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    t.push_back(st(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'b00011));  // branch
    t.push_back(st(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'b10011));  // branch in FLUSH
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 5'b10011));  // jump killed
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (flush_cnt !== exp_flush_cnt) begin
      n_bad++;
      $display("FAIL b2b_flush_cnt: got %h want %h", flush_cnt, exp_flush_cnt);
    end
  endtask

  task automatic test_saturate();
    stim_t s;
    logic [4:0] e;
    int n = 87401;
    // Self-dependent r3 writer: one issue then three stall cycles, repeating.
    for (int i = 0; i < n; i++) begin
      if (i == 0)          e = 5'b00000;
      else if (i % 4 == 0) e = 5'b01000;
      else if (i % 4 == 1) e = 5'b00110;
      else                 e = 5'b01110;
      s = st(0, (i == 0), 1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, e);
      drive_cycle(s);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL sat[%0d]: got %b want %b", i, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (stall_cnt !== 16'hFFFF || exp_stall_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_cnt: got %h want ffff (model %h)", stall_cnt, exp_stall_cnt);
    end
    // clr_cnt during a stall cycle wins over the increment.
    drive_cycle(st(0, 1, 1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'b00110));
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL sat_clr_cycle: got %b want %b", obs_v, exp_v);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL sat_clr_cnt: got %h want 0000", stall_cnt);
    end
    drive_cycle(idle(5'b01000));
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL sat_drain: got %b want %b", obs_v, exp_v);
    end
    drive_cycle(idle(5'b00000));
    void'(exp_q.pop_front());
    drive_cycle(idle(5'b00000));
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    t.push_back(st(0, 0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0, 5'b00000));  // write r3
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b00110));  // stall 1
    t.push_back(st(1, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b01000));  // reset in stall 2
    t.push_back(st(0, 0, 1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 5'b00000));  // issues cleanly
    t.push_back(idle(5'b00000));
    foreach (t[k]) begin
      drive_cycle(t[k]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got %b want %b", k, obs_v, exp_v);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {exp_stall_cnt, exp_flush_cnt}) begin
      n_bad++;
      $display("FAIL rst_mid_cnt: got %h/%h want %h/%h", stall_cnt, flush_cnt,
               exp_stall_cnt, exp_flush_cnt);
    end
  endtask

  // Test sequence and final report
  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_stall_cnt = 16'd0;
    exp_flush_cnt = 16'd0;
    rst = 1'b1;
    clr_cnt = 1'b0;
    d_valid = 1'b0;
    d_rs = 5'd0;
    d_rt = 5'd0;
    d_use_rs = 1'b0;
    d_use_rt = 1'b0;
    d_wr = 1'b0;
    d_wr_addr = 5'd0;
    d_jump = 1'b0;
    br_taken = 1'b0;
    test_reset();
    test_r0_and_unused();
    test_raw();
    test_jump();
    test_branch();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
